// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive 16-minterm truth-table capture sequencer
// Optional feature: define SCAN_CHECK_EN to register a golden-table comparison on `match`.
module truth_table_scanner #(
    parameter int          SETTLE_CYCLES  = 1,
    parameter logic [15:0] EXPECTED_TABLE = 16'h28AC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        f_in,
    output logic [3:0]  sel,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        table_valid,
    output logic [4:0]  ones_count,
    output logic        match
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Settle counter terminal value; counter counts DRIVE cycles from 0.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t      state_q;
    logic [3:0]  sel_q;
    logic        en_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] table_q;
    logic        valid_q;
    logic [4:0]  ones_q;
    logic [3:0]  settle_q;

    logic [15:0] table_d;
    logic [4:0]  ones_d;
    logic [3:0]  settle_d;

    // Next-value helpers: table with the current minterm written in, running popcount, settle step.
    always_comb begin
        table_d          = table_q;
        table_d[sel_q]   = f_in;
        ones_d           = ones_q + {4'b0000, f_in};
        settle_d         = settle_q + 4'd1;
    end

    // Scan sequencer: abort pre-empts every non-idle transition, rst pre-empts everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 4'd0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            table_q  <= 16'h0000;
            valid_q  <= 1'b0;
            ones_q   <= 5'd0;
            settle_q <= 4'd0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                table_q  <= 16'h0000;
                ones_q   <= 5'd0;
                valid_q  <= 1'b0;
                sel_q    <= 4'd0;
                en_q     <= 1'b1;
                busy_q   <= 1'b1;
                settle_q <= 4'd0;
                state_q  <= S_DRIVE;
            end
        end else if (abort) begin
            // Partial table and count are kept for inspection; no completion is signalled.
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_DRIVE: begin
                    settle_q <= settle_d;
                    if (settle_d == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    table_q <= table_d;
                    ones_q  <= ones_d;
                    if (sel_q == 4'd15) begin
                        state_q <= S_DONE;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        sel_q    <= sel_q + 4'd1;
                        settle_q <= 4'd0;
                        state_q  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_CHECK_EN
    logic match_q;

    // Golden comparison is taken on the completing capture, including the final minterm.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                match_q <= 1'b0;
            end
        end else if (abort) begin
            match_q <= 1'b0;
        end else if ((state_q == S_SAMPLE) && (sel_q == 4'd15)) begin
            match_q <= (table_d == EXPECTED_TABLE);
        end
    end

    assign match = match_q;
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED_TABLE;
    assign match           = 1'b0;
`endif

    assign sel         = sel_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign table_out   = table_q;
    assign table_valid = valid_q;
    assign ones_count  = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - self-checking bench for truth_table_scanner at settle 1, 2 and 3
module tb_truth_table_scanner;

    localparam logic [15:0] GOLD = 16'h28AC;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        f_w        [3];
    logic [3:0]  sel_w      [3];
    logic        en_w       [3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic [15:0] tab_w      [3];
    logic        tv_w       [3];
    logic [4:0]  ones_w     [3];
    logic        match_w    [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance j runs with settle time j+1.
    for (genvar j = 0; j < 3; j++) begin : g_dut
        truth_table_scanner #(
            .SETTLE_CYCLES (j + 1),
            .EXPECTED_TABLE(GOLD)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .abort      (abort),
            .f_in       (f_w[j]),
            .sel        (sel_w[j]),
            .en         (en_w[j]),
            .busy       (busy_w[j]),
            .done       (done_w[j]),
            .table_out  (tab_w[j]),
            .table_valid(tv_w[j]),
            .ones_count (ones_w[j]),
            .match      (match_w[j])
        );
    end

    // Expected outputs c cycles after the accepting start edge.
    // ev_kind: 0 none, 1 reset asserted for edge ev_c, 2 abort asserted for edge ev_c.
    function automatic logic [29:0] model(input int s, input int c, input int ev_kind,
                                          input int ev_c, input logic [15:0] tt);
        int          p;
        int          t;
        int          n;
        int          selv;
        logic        b;
        logic        e;
        logic        d;
        logic        v;
        logic        m;
        logic [15:0] mask;
        logic [15:0] tab;
        p = s + 1;
        t = 16 * p;
        if (ev_kind == 1 && c >= ev_c) return 30'd0;
        if (ev_kind == 2 && c >= ev_c) begin
            n    = (ev_c - 1) / p;
            selv = n;
            b = 1'b0; e = 1'b0; d = 1'b0; v = 1'b0; m = 1'b0;
        end else begin
            n = c / p;
            if (n > 16) n = 16;
            selv = (c < t) ? c / p : 15;
            b = (c <= t);
            e = (c < t);
            d = (c == t);
            v = (c >= t);
`ifdef SCAN_CHECK_EN
            m = v && (tt == GOLD);
`else
            m = 1'b0;
`endif
        end
        mask = (n >= 16) ? 16'hFFFF : 16'((1 << n) - 1);
        tab  = tt & mask;
        return {b, e, d, v, m, 4'(selv), 5'($countones(tab)), tab};
    endfunction

    task automatic check(input int j, input int c, input logic [29:0] exp_v);
        logic [29:0] obs;
        obs = {busy_w[j], en_w[j], done_w[j], tv_w[j], match_w[j], sel_w[j], ones_w[j], tab_w[j]};
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL dut%0d_cycle%0d {busy,en,done,valid,match,sel,ones,table} observed=%h expected=%h",
                   j, c, obs, exp_v);
        end
    endtask

    // One scan on all three instances, checked every cycle against the model.
    task automatic scan(input logic [15:0] tt, input bit glitch, input int ev_kind,
                        input int ev_c, input int restart_c, input bit with_abort);
        int p;
        int idx;
        for (int j = 0; j < 3; j++) f_w[j] = tt[0];
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            for (int j = 0; j < 3; j++) check(j, c, model(j + 1, c, ev_kind, ev_c, tt));
            start = (c == restart_c);
            abort = (ev_kind == 2 && c == ev_c - 1);
            rst   = (ev_kind == 1 && c == ev_c - 1);
            for (int j = 0; j < 3; j++) begin
                p   = j + 2;
                idx = c / p;
                if (idx > 15) idx = 15;
                if (glitch && !((c % p) == (j + 1) && c < 16 * p))
                    f_w[j] = 1'($urandom);
                else
                    f_w[j] = tt[idx];
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        for (int j = 0; j < 3; j++) f_w[j] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) check(j, -1, 30'd0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;

        // Prime function unit, clean input.
        scan(GOLD, 1'b0, 0, 0, -1, 1'b0);
        // Constant-true unit with glitches outside the sampling cycle.
        scan(16'hFFFF, 1'b1, 0, 0, -1, 1'b0);
        // Start re-pulsed mid-scan is ignored.
        scan(16'($urandom), 1'b1, 0, 0, 10, 1'b0);
        // Reset while the settle-1 instance is at minterm 7.
        scan(16'($urandom), 1'b0, 1, 15, -1, 1'b0);
        // Clean scan after reset; abort alongside start in idle has no effect.
        scan(16'($urandom), 1'b0, 0, 0, -1, 1'b1);
        // Abort on the final sampling edge of the settle-1 instance.
        scan(16'($urandom), 1'b1, 2, 32, -1, 1'b0);
        // Scan after abort, then random tables.
        for (int k = 0; k < 3; k++) scan(16'($urandom), 1'b1, 0, 0, -1, 1'b0);
        scan(16'h0000, 1'b1, 0, 0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
